// File: rtl/seg_scan_driver_if.sv
// Display-side bundle between the processor top level and the seven-segment scan driver.
// The master drives the data words and switch; the slave returns the anode and segment lines.
interface seg_scan_driver_if;
   logic [31:0] inst;
   logic [31:0] alu_in;
   logic [31:0] pc_in;
   logic [2:0]  switch;
   logic [3:0]  enable;
   logic [6:0]  led_out;

   modport master (
      output inst, alu_in, pc_in, switch,
      input  enable, led_out
   );

   modport slave (
      input  inst, alu_in, pc_in, switch,
      output enable, led_out
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with a per-frame snapshot and
// anti-ghost blanking at the start of each digit slot.
module seg_scan_driver #(
   parameter int REFRESH_DIV = 8,
   parameter int GHOST       = 2
) (
   input  logic              clk,
   input  logic              reset,
   seg_scan_driver_if.slave  bus
);

   localparam int             CW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]  LAST   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]  GHOST_C = CW'(GHOST);

   logic [2:0]    sw_m;
   logic [2:0]    sw_s;
   logic [CW-1:0] cnt;
   logic [1:0]    d;
   logic [15:0]   snap;
   logic          blank;
   logic [3:0]    enable_q;
   logic [6:0]    led_q;

   logic          cnt_wrap;
   logic          frame_end;
   logic [31:0]   sel_word;
   logic [15:0]   sel_half;
   logic          in_ghost;
   logic [3:0]    enable_nxt;
   logic [6:0]    led_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0:    hex7 = 7'b0000001;
         4'h1:    hex7 = 7'b1001111;
         4'h2:    hex7 = 7'b0010010;
         4'h3:    hex7 = 7'b0000110;
         4'h4:    hex7 = 7'b1001100;
         4'h5:    hex7 = 7'b0100100;
         4'h6:    hex7 = 7'b0100000;
         4'h7:    hex7 = 7'b0001111;
         4'h8:    hex7 = 7'b0000000;
         4'h9:    hex7 = 7'b0000100;
         4'hA:    hex7 = 7'b0001000;
         4'hB:    hex7 = 7'b1100000;
         4'hC:    hex7 = 7'b0110001;
         4'hD:    hex7 = 7'b1000010;
         4'hE:    hex7 = 7'b0110000;
         default: hex7 = 7'b0111000;
      endcase
   endfunction

   // switch is a board input with no relation to clk
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_m <= 3'b000;
         sw_s <= 3'b000;
      end else begin
         sw_m <= bus.switch;
         sw_s <= sw_m;
      end
   end

   assign cnt_wrap  = (cnt == LAST);
   assign frame_end = cnt_wrap && (d == 2'd3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         d   <= 2'd0;
      end else if (cnt_wrap) begin
         cnt <= '0;
         d   <= d + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      sel_word = 32'h0;
      case (sw_s[2:1])
         2'b00:   sel_word = bus.inst;
         2'b01:   sel_word = bus.alu_in;
         2'b10:   sel_word = bus.pc_in;
         default: sel_word = 32'h0;
      endcase
      sel_half = sw_s[0] ? sel_word[31:16] : sel_word[15:0];
   end

   // Snapshot only at frame end so a frame never mixes old and new data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap  <= 16'h0;
         blank <= 1'b1;
      end else if (frame_end) begin
         snap  <= sel_half;
         blank <= (sw_s[2:1] == 2'b11);
      end
   end

   assign in_ghost = (cnt < GHOST_C);

   always_comb begin
      enable_nxt = 4'hF;
      led_nxt    = 7'h7F;
      if (!in_ghost && !blank) begin
         enable_nxt[d] = 1'b0;
         led_nxt       = hex7(snap[{d, 2'b00} +: 4]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable_q <= 4'hF;
         led_q    <= 7'h7F;
      end else begin
         enable_q <= enable_nxt;
         led_q    <= led_nxt;
      end
   end

   assign bus.enable  = enable_q;
   assign bus.led_out = led_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: per-frame expectations are queued when inputs are set
// and compared cycle by cycle as the display scans.
module tb_seg_scan_driver;
   localparam int RD    = 8;
   localparam int GH    = 2;
   localparam int FRAME = 4 * RD;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   k     = 0;
   int   checks = 0;
   int   errors = 0;

   seg_scan_driver_if bus();

   seg_scan_driver #(.REFRESH_DIV(RD), .GHOST(GH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // k = clk edges since reset release
   always @(posedge clk or negedge reset) begin
      if (!reset) k <= 0;
      else        k <= k + 1;
   end

   typedef struct {
      int         cyc;
      logic [3:0] en;
      logic [6:0] led;
      string      tag;
   } exp_t;

   typedef struct {
      logic [2:0]  sw;
      logic [31:0] inst;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [15:0] val;
      bit          blk;
   } vec_t;

   exp_t q[$];
   exp_t e;
   vec_t vt[9];

   function automatic logic [6:0] seg(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      return t[n];
   endfunction

   // Frame f scans during edges FRAME*f+1 .. FRAME*f+FRAME
   task automatic push_frame(input int f, input logic [15:0] val, input bit blk, input string tag);
      exp_t x;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < RD; c++) begin
            x.cyc = FRAME * f + RD * s + 1 + c;
            x.tag = tag;
            x.en  = 4'hF;
            x.led = 7'h7F;
            if (!blk && c >= GH) begin
               x.en[s] = 1'b0;
               x.led   = seg(val[4*s +: 4]);
            end
            q.push_back(x);
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         while (q.size() > 0 && q[0].cyc <= k) begin
            e = q.pop_front();
            checks++;
            if (e.cyc < k || bus.enable !== e.en || bus.led_out !== e.led) begin
               errors++;
               $display("FAIL %s cyc=%0d k=%0d: enable=%b led_out=%b, want %b %b",
                        e.tag, e.cyc, k, bus.enable, bus.led_out, e.en, e.led);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [3:0] en, input logic [6:0] led);
      checks++;
      if (bus.enable !== en || bus.led_out !== led) begin
         errors++;
         $display("FAIL %s: enable=%b led_out=%b, want %b %b", nm, bus.enable, bus.led_out, en, led);
      end
   endtask

   task automatic wait_k(input int t);
      int g;
      g = 0;
      while (k < t) begin
         @(negedge clk);
         g++;
         if (g > 5000) begin
            errors++;
            $display("FAIL wait_k timeout: k=%0d, want %0d", k, t);
            $fatal(1, "bench stalled");
         end
      end
   endtask

   initial begin
      int f;
      vt[0] = '{3'b000, 32'h1234ABCD, 32'h0,        32'h0,        16'hABCD, 1'b0};
      vt[1] = '{3'b001, 32'h1234ABCD, 32'h0,        32'h0,        16'h1234, 1'b0};
      vt[2] = '{3'b000, 32'h76543210, 32'h0,        32'h0,        16'h3210, 1'b0};
      vt[3] = '{3'b001, 32'h76543210, 32'h0,        32'h0,        16'h7654, 1'b0};
      vt[4] = '{3'b010, 32'h0,        32'hFEDCBA98, 32'h0,        16'hBA98, 1'b0};
      vt[5] = '{3'b011, 32'h0,        32'hFEDCBA98, 32'h0,        16'hFEDC, 1'b0};
      vt[6] = '{3'b100, 32'h0,        32'h0,        32'h00400008, 16'h0008, 1'b0};
      vt[7] = '{3'b101, 32'h0,        32'h0,        32'h00400008, 16'h0040, 1'b0};
      vt[8] = '{3'b111, 32'h5555AAAA, 32'h5555AAAA, 32'h5555AAAA, 16'h0000, 1'b1};

      bus.switch = 3'b000;
      bus.inst   = 32'h1234ABCD;
      bus.alu_in = 32'h0;
      bus.pc_in  = 32'h0;

      repeat (3) @(negedge clk);
      chk("reset_hold", 4'hF, 7'h7F);
      reset = 1'b1;
      push_frame(0, 16'h0, 1'b1, "dark_after_reset");

      for (int i = 0; i < 9; i++) begin
         wait_k(FRAME * i);
         bus.switch = vt[i].sw;
         bus.inst   = vt[i].inst;
         bus.alu_in = vt[i].alu;
         bus.pc_in  = vt[i].pc;
         push_frame(i + 1, vt[i].val, vt[i].blk, $sformatf("vec%0d", i));
      end
      f = 9;

      // switch flip mid-frame stays invisible until the next frame end
      wait_k(FRAME * f);
      bus.switch = 3'b101;
      bus.pc_in  = 32'h00400008;
      push_frame(f + 1, 16'h0040, 1'b0, "pc_hi");
      wait_k(FRAME * (f + 1) + 2 * RD);
      bus.switch = 3'b100;
      push_frame(f + 2, 16'h0008, 1'b0, "pc_lo_after_flip");
      f += 2;

      // word change while digit 1 is up must not tear the frame
      wait_k(FRAME * f);
      bus.switch = 3'b010;
      bus.alu_in = 32'h00001111;
      push_frame(f + 1, 16'h1111, 1'b0, "alu_1111");
      wait_k(FRAME * (f + 1) + RD);
      bus.alu_in = 32'h00002222;
      push_frame(f + 2, 16'h2222, 1'b0, "alu_2222");
      f += 2;

      wait_k(FRAME * f);
      bus.switch = 3'b110;
      push_frame(f + 1, 16'h0, 1'b1, "blank_sel");
      f += 1;

      wait_k(FRAME * f);
      bus.switch = 3'b000;
      bus.inst   = 32'h1234ABCD;
      push_frame(f + 1, 16'hABCD, 1'b0, "pre_reset");
      f += 1;

      // async reset at d=2, cnt=5
      wait_k(FRAME * f + 2 * RD + 5);
      chk("lit_before_reset", 4'b1011, seg(4'hB));
      q.delete();
      reset = 1'b0;
      #1;
      chk("async_reset_dark", 4'hF, 7'h7F);
      repeat (3) begin
         @(negedge clk);
         chk("reset_held_dark", 4'hF, 7'h7F);
      end
      reset = 1'b1;
      push_frame(0, 16'h0, 1'b1, "dark_after_rereset");
      push_frame(1, 16'hABCD, 1'b0, "first_frame_after_rereset");
      wait_k(2 * FRAME);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: %0d entries left, want 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the board's 4-digit seven-segment display, sitting downstream of the processor top level. It consumes the fetched instruction, ALU result and PC as 32-bit words and selects one 16-bit half of one word with the 3-bit switch input. It snapshots that value once per scan frame and drives one digit at a time, with anti-ghost blanking between digits. It runs on the slow display clock domain and replaces the free-running display logic.

## Interface
- REFRESH_DIV, 8: clock cycles per digit slot; legal range ≥ GHOST+1 and ≥ 2; counter width is clog2(REFRESH_DIV).
- GHOST, 2: cycles at the start of each digit slot during which all digits are off; legal range ≥ 0.
- clk  in  1  display clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst  in  32  fetched instruction word.
- alu_in  in  32  ALU result word.
- pc_in  in  32  program counter.
- switch  in  3  switch[2:1] selects the source word; switch[0] selects the half. Asynchronous to clk.
- enable  out  4  digit anodes, active-low; enable[0] is the rightmost digit.
- led_out  out  7  segments {a,b,c,d,e,f,g}, active-low.

## Operation
- switch passes through a 2-flop synchronizer (sw_s); only sw_s is used internally.
- Source select on sw_s[2:1]:
  - 00 = inst
  - 01 = alu_in
  - 10 = pc_in
  - 11 = blank, all segments off.
- Half select: sw_s[0]=0 selects bits [15:0]; sw_s[0]=1 selects bits [31:16].
- Prescaler cnt runs 0..REFRESH_DIV-1 and wraps. On wrap, digit index d advances 0→1→2→3→0.
- Snapshot: in the cycle where cnt==REFRESH_DIV-1 and d==3 (frame end):
  - snap[15:0] loads the selected half;
  - blank loads (sw_s[2:1]==11).
  - snap and blank are otherwise held, so changes to the inputs or switch mid-frame are never visible within a frame.
- Digit d shows nibble snap[4d+3:4d].
- Hex decode (active-low abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Output function f(cnt,d,snap,blank):
  - if cnt<GHOST or blank: enable=1111 and led_out=1111111;
  - else enable = all ones except bit d = 0, and led_out = decode(nibble d).
- Reset values (asynchronous, while reset=0):
  - cnt=0, d=0, snap=0, blank=1, sync flops=000;
  - enable=1111, led_out=1111111.
- The display is dark from reset release until the first frame-end snapshot, i.e. for 4·REFRESH_DIV cycles.
- Reset asserted mid-frame: all outputs go dark immediately, without waiting for a clock edge. The next frame restarts at d=0, cnt=0.

## Timing
- enable and led_out are registered. Their value after edge t+1 equals f(cnt,d,snap,blank) as held after edge t, giving one cycle of latency behind the counter state.
- Switch-to-display latency:
  - 2 cycles of synchronization;
  - then wait for the next frame end;
  - then 1 output cycle.
  - Worst case is 2 + 4·REFRESH_DIV + 1 cycles.
- Input-word-to-display latency: the value sampled at frame end appears on digit 0 after that frame's wrap. Digit 0 is dark for GHOST cycles first, so the value becomes visible GHOST+1 cycles after the snapshot edge.
- Every digit slot lasts exactly REFRESH_DIV cycles: GHOST dark cycles, then REFRESH_DIV-GHOST lit cycles. A frame lasts 4·REFRESH_DIV cycles.
- Never more than one enable bit is low in any cycle.
- enable and led_out change only on clk edges, except at asynchronous reset.

## Test plan
- Reset hold and release (REFRESH_DIV=8, GHOST=2): assert reset and release it; enable=1111 and led_out=1111111 during reset and for the next 32 cycles.
- Lower half of inst: switch=000, inst=0x1234ABCD. After the first snapshot, digits show A,B,C,D:
  - digit 0: enable=1110, led_out=1000010 (d);
  - digit 1: enable=1101, led_out=0110001 (C);
  - digit 2: enable=1011, led_out=1100000 (b);
  - digit 3: enable=0111, led_out=0001000 (A).
  - Each digit is lit for 6 of its 8 cycles.
- Source and half change: switch=101 with pc_in=0x00400008 shows digits 0040 (digit 3 = 0000001). Flipping switch to 100 mid-frame has no effect until the next frame end, after which the display shows 0008.
- Snapshot coherence: switch=010; change alu_in from 0x00001111 to 0x00002222 while d=1. The remaining digits of the current frame still show 1 (1001111); the next frame shows 2222.
- Blank select: switch=110. After the frame end, enable stays 1111 for the entire following frame.
- Async reset mid-slot: drop reset while cnt=5 and d=2. enable and led_out become all ones before the next clk edge. After release, the display stays dark for 32 cycles, and the first lit digit is digit 0.
